// File: rtl/alu_op_sequencer.sv
// Issue-side ALU front end: decodes ALUOp/funct to the ALU control code, stages
// operands onto the combinational ALU, holds them for the op latency and registers the response.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for a request, ready_o high
//   S_EXEC | ALU inputs held, down-counter running to terminal count 1
//   S_RESP | response registered, out_valid_o high until out_ready_i
module alu_op_sequencer #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [3:0]        aluop_i,
  input  logic [5:0]        funct_i,
  input  logic [4:0]        shamt_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [3:0]        alu_ctrl_o,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              branch_taken_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] C_AND  = 4'd0;
  localparam logic [3:0] C_OR   = 4'd1;
  localparam logic [3:0] C_ADD  = 4'd2;
  localparam logic [3:0] C_SLTU = 4'd3;
  localparam logic [3:0] C_SLT  = 4'd4;
  localparam logic [3:0] C_MUL  = 4'd5;
  localparam logic [3:0] C_SUB  = 4'd6;
  localparam logic [3:0] C_BEQ  = 4'd7;
  localparam logic [3:0] C_SRA  = 4'd8;
  localparam logic [3:0] C_SRAV = 4'd9;
  localparam logic [3:0] C_BNE  = 4'd10;
  localparam logic [3:0] C_LUI  = 4'd11;
  localparam logic [3:0] C_SGT  = 4'd12;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] ONE_CNT = 4'd1;

  state_t              state;
  logic [3:0]          cnt;

  logic [3:0]          dec_code;
  logic                dec_illegal;
  logic                dec_use_imm;
  logic [DATA_W-1:0]   dec_src1;
  logic [DATA_W-1:0]   dec_src2;

  always_comb begin
    dec_code    = C_AND;
    dec_illegal = 1'b0;
    dec_use_imm = 1'b0;
    case (aluop_i)
      4'd0: begin
        case (funct_i)
          6'h24:   dec_code = C_AND;
          6'h25:   dec_code = C_OR;
          6'h20:   dec_code = C_ADD;
          6'h2A:   dec_code = C_SLT;
          6'h18:   dec_code = C_MUL;
          6'h22:   dec_code = C_SUB;
          6'h03:   dec_code = C_SRA;
          6'h07:   dec_code = C_SRAV;
          6'h2C:   dec_code = C_SGT;
          default: dec_illegal = 1'b1;
        endcase
      end
      4'd1: begin dec_code = C_ADD;  dec_use_imm = 1'b1; end
      4'd2: begin dec_code = C_SLTU; dec_use_imm = 1'b1; end
      4'd3: dec_code = C_BEQ;
      4'd4: dec_code = C_BNE;
      4'd5: begin dec_code = C_LUI;  dec_use_imm = 1'b1; end
      4'd6: begin dec_code = C_OR;   dec_use_imm = 1'b1; end
      4'd7: begin dec_code = C_ADD;  dec_use_imm = 1'b1; end
      default: dec_illegal = 1'b1;
    endcase
  end

  // sra carries its shift amount in src1[10:6], the position the ALU reads it from
  always_comb begin
    dec_src1 = rs_data_i;
    dec_src2 = dec_use_imm ? imm_i : rt_data_i;
    if (!dec_illegal && dec_code == C_SRA) begin
      dec_src1 = {{(DATA_W-11){1'b0}}, shamt_i, 6'b0};
      dec_src2 = rt_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      ready_o        <= 1'b1;
      alu_ctrl_o     <= 4'd0;
      alu_src1_o     <= '0;
      alu_src2_o     <= '0;
      out_valid_o    <= 1'b0;
      result_o       <= '0;
      zero_o         <= 1'b0;
      branch_taken_o <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_i && ready_o) begin
            ready_o    <= 1'b0;
            alu_ctrl_o <= dec_code;
            alu_src1_o <= dec_src1;
            alu_src2_o <= dec_src2;
            if (dec_illegal) begin
              state          <= S_RESP;
              cnt            <= 4'd0;
              out_valid_o    <= 1'b1;
              err_o          <= 1'b1;
              result_o       <= '0;
              zero_o         <= 1'b0;
              branch_taken_o <= 1'b0;
            end else begin
              state <= S_EXEC;
              err_o <= 1'b0;
              cnt   <= (dec_code == C_MUL) ? MUL_CNT : ONE_CNT;
            end
          end
        end
        S_EXEC: begin
          // terminal count is 1 so a single-cycle op captures on its first EXEC edge
          if (cnt <= ONE_CNT) begin
            state          <= S_RESP;
            cnt            <= 4'd0;
            out_valid_o    <= 1'b1;
            result_o       <= alu_result_i;
            zero_o         <= alu_zero_i;
            branch_taken_o <= alu_zero_i &&
                              (alu_ctrl_o == C_BEQ || alu_ctrl_o == C_BNE);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (out_ready_i) begin
            state       <= S_IDLE;
            out_valid_o <= 1'b0;
            ready_o     <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural combinational ALU attached.
module tb_alu_op_sequencer;

  localparam int DATA_W  = 32;
  localparam int MUL_LAT = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              valid_i;
  logic              ready_o;
  logic [3:0]        aluop_i;
  logic [5:0]        funct_i;
  logic [4:0]        shamt_i;
  logic [DATA_W-1:0] rs_data_i;
  logic [DATA_W-1:0] rt_data_i;
  logic [DATA_W-1:0] imm_i;
  logic [3:0]        alu_ctrl_o;
  logic [DATA_W-1:0] alu_src1_o;
  logic [DATA_W-1:0] alu_src2_o;
  logic [DATA_W-1:0] alu_result_i;
  logic              alu_zero_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] result_o;
  logic              zero_o;
  logic              branch_taken_o;
  logic              err_o;

  int vectors     = 0;
  int miscompares = 0;

  alu_op_sequencer #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .aluop_i(aluop_i), .funct_i(funct_i), .shamt_i(shamt_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .alu_ctrl_o(alu_ctrl_o), .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .zero_o(zero_o),
    .branch_taken_o(branch_taken_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference ALU on the staged inputs
  always_comb begin
    alu_result_i = '0;
    case (alu_ctrl_o)
      4'd0:  alu_result_i = alu_src1_o & alu_src2_o;
      4'd1:  alu_result_i = alu_src1_o | alu_src2_o;
      4'd2:  alu_result_i = alu_src1_o + alu_src2_o;
      4'd3:  alu_result_i = {31'b0, alu_src1_o < alu_src2_o};
      4'd4:  alu_result_i = {31'b0, $signed(alu_src1_o) < $signed(alu_src2_o)};
      4'd5:  alu_result_i = alu_src1_o * alu_src2_o;
      4'd6:  alu_result_i = alu_src1_o - alu_src2_o;
      4'd7:  alu_result_i = alu_src1_o - alu_src2_o;
      4'd8:  alu_result_i = $signed(alu_src2_o) >>> alu_src1_o[10:6];
      4'd9:  alu_result_i = $signed(alu_src2_o) >>> alu_src1_o[4:0];
      4'd10: alu_result_i = {31'b0, alu_src1_o == alu_src2_o};
      4'd11: alu_result_i = {alu_src2_o[15:0], 16'b0};
      4'd12: alu_result_i = {31'b0, $signed(alu_src1_o) > $signed(alu_src2_o)};
      default: alu_result_i = '0;
    endcase
    alu_zero_i = (alu_result_i == '0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  // Presents a request for one edge; returns at the negedge of cycle N+1
  task automatic issue(input logic [3:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] im);
    aluop_i = op; funct_i = fn; shamt_i = sh;
    rs_data_i = rs; rt_data_i = rt; imm_i = im;
    valid_i = 1'b1;
    cyc();
    valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; out_ready_i = 1'b1;
    aluop_i = 4'd0; funct_i = 6'd0; shamt_i = 5'd0;
    rs_data_i = '0; rt_data_i = '0; imm_i = '0;
    cyc(); cyc();
    rst_i = 1'b0;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_ctrl", 32'(alu_ctrl_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);

    // add 5 + 7
    issue(4'd0, 6'h20, 5'd0, 32'd5, 32'd7, 32'd99);
    chk("add_ctrl", 32'(alu_ctrl_o), 32'd2);
    chk("add_n1_valid", 32'(out_valid_o), 32'd0);
    chk("add_n1_ready", 32'(ready_o), 32'd0);
    cyc();
    chk("add_valid", 32'(out_valid_o), 32'd1);
    chk("add_result", result_o, 32'd12);
    chk("add_zero", 32'(zero_o), 32'd0);
    cyc();
    chk("add_done_valid", 32'(out_valid_o), 32'd0);
    chk("add_done_ready", 32'(ready_o), 32'd1);

    // mul 6 * -3, operand inputs scrambled while busy
    issue(4'd0, 6'h18, 5'd0, 32'd6, 32'hFFFF_FFFD, 32'd0);
    rs_data_i = 32'h1234_5678; rt_data_i = 32'h0BAD_F00D; funct_i = 6'h20;
    for (int i = 1; i <= MUL_LAT; i++) begin
      chk("mul_ctrl_hold", 32'(alu_ctrl_o), 32'd5);
      chk("mul_src1_hold", alu_src1_o, 32'd6);
      chk("mul_exec_valid", 32'(out_valid_o), 32'd0);
      chk("mul_exec_ready", 32'(ready_o), 32'd0);
      cyc();
    end
    chk("mul_valid", 32'(out_valid_o), 32'd1);
    chk("mul_result", result_o, 32'hFFFF_FFEE);
    cyc();
    chk("mul_done_valid", 32'(out_valid_o), 32'd0);
    chk("mul_done_ready", 32'(ready_o), 32'd1);

    // beq equal: taken
    issue(4'd3, 6'h00, 5'd0, 32'd9, 32'd9, 32'd0);
    chk("beq_ctrl", 32'(alu_ctrl_o), 32'd7);
    cyc();
    chk("beq_valid", 32'(out_valid_o), 32'd1);
    chk("beq_zero", 32'(zero_o), 32'd1);
    chk("beq_taken", 32'(branch_taken_o), 32'd1);
    cyc();

    // bne equal: not taken
    issue(4'd4, 6'h00, 5'd0, 32'd9, 32'd9, 32'd0);
    chk("bne_ctrl", 32'(alu_ctrl_o), 32'd10);
    cyc();
    chk("bne_zero", 32'(zero_o), 32'd0);
    chk("bne_taken", 32'(branch_taken_o), 32'd0);
    cyc();

    // sra by 4
    issue(4'd0, 6'h03, 5'd4, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    chk("sra_ctrl", 32'(alu_ctrl_o), 32'd8);
    chk("sra_src1", alu_src1_o, 32'h0000_0100);
    chk("sra_src2", alu_src2_o, 32'h8000_0000);
    cyc();
    chk("sra_result", result_o, 32'hF800_0000);
    chk("sra_taken", 32'(branch_taken_o), 32'd0);
    cyc();

    // addi and lui take the immediate
    issue(4'd1, 6'h00, 5'd0, 32'd100, 32'd55, 32'hFFFF_FFFF);
    chk("addi_src2", alu_src2_o, 32'hFFFF_FFFF);
    cyc();
    chk("addi_result", result_o, 32'd99);
    cyc();
    issue(4'd5, 6'h00, 5'd0, 32'd0, 32'd77, 32'h0000_1234);
    chk("lui_ctrl", 32'(alu_ctrl_o), 32'd11);
    cyc();
    chk("lui_result", result_o, 32'h1234_0000);
    cyc();

    // illegal funct under backpressure, with a legal request held meanwhile
    out_ready_i = 1'b0;
    issue(4'd0, 6'h3F, 5'd0, 32'd1, 32'd2, 32'd0);
    chk("ill_valid", 32'(out_valid_o), 32'd1);
    chk("ill_err", 32'(err_o), 32'd1);
    chk("ill_result", result_o, 32'd0);
    chk("ill_zero", 32'(zero_o), 32'd0);
    aluop_i = 4'd0; funct_i = 6'h20; rs_data_i = 32'd40; rt_data_i = 32'd2;
    valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_valid", 32'(out_valid_o), 32'd1);
      chk("bp_err", 32'(err_o), 32'd1);
      chk("bp_result", result_o, 32'd0);
      chk("bp_ready", 32'(ready_o), 32'd0);
    end
    valid_i = 1'b0;
    out_ready_i = 1'b1;
    cyc();
    chk("ill_rel_valid", 32'(out_valid_o), 32'd0);
    chk("ill_rel_ready", 32'(ready_o), 32'd1);
    chk("ill_rel_err", 32'(err_o), 32'd1);
    issue(4'd0, 6'h20, 5'd0, 32'd1, 32'd2, 32'd0);
    chk("clr_err", 32'(err_o), 32'd0);
    cyc();
    chk("clr_result", result_o, 32'd3);
    cyc();

    // illegal aluop class
    issue(4'd9, 6'h20, 5'd0, 32'd1, 32'd2, 32'd0);
    chk("ill9_valid", 32'(out_valid_o), 32'd1);
    chk("ill9_err", 32'(err_o), 32'd1);
    cyc();

    // reset in the middle of a mul
    issue(4'd0, 6'h18, 5'd0, 32'd7, 32'd7, 32'd0);
    cyc();
    rst_i = 1'b1;
    cyc(); cyc();
    rst_i = 1'b0;
    chk("mrst_ready", 32'(ready_o), 32'd1);
    chk("mrst_valid", 32'(out_valid_o), 32'd0);
    chk("mrst_ctrl", 32'(alu_ctrl_o), 32'd0);
    chk("mrst_result", result_o, 32'd0);
    chk("mrst_err", 32'(err_o), 32'd0);
    for (int i = 0; i < MUL_LAT + 2; i++) begin
      cyc();
      chk("mrst_no_resp", 32'(out_valid_o), 32'd0);
    end

    // sub after reset
    issue(4'd0, 6'h22, 5'd0, 32'd10, 32'd10, 32'd0);
    chk("sub_ctrl", 32'(alu_ctrl_o), 32'd6);
    cyc();
    chk("sub_zero", 32'(zero_o), 32'd1);
    chk("sub_taken", 32'(branch_taken_o), 32'd0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue-side front end of the datapath ALU. It decodes ALUOp/funct into the 4-bit ALU control code and stages the operands onto the ALU inputs.
- Holds those inputs stable for the required number of cycles (multi-cycle for mul) and captures result/zero into a response register with valid/ready handshakes on both sides.
- Sits between the decode stage and the combinational ALU. It replaces the ad-hoc combinational ALU control path.

Parameters:
- DATA_W, 32, operand/result width (ALU is fixed at 32).
- MUL_LAT, 4, EXEC cycles held for mul (code 5); legal range 1..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- valid_i  in  1  request valid
- ready_o  out  1  request accept
- aluop_i  in  4  op class: 0 R-type, 1 addi, 2 sltiu, 3 beq, 4 bne, 5 lui, 6 ori, 7 lw/sw
- funct_i  in  6  R-type function field
- shamt_i  in  5  shift amount
- rs_data_i  in  DATA_W  rs operand
- rt_data_i  in  DATA_W  rt operand
- imm_i  in  DATA_W  sign-extended immediate
- alu_ctrl_o  out  4  ALU control code
- alu_src1_o  out  DATA_W  ALU src1
- alu_src2_o  out  DATA_W  ALU src2
- alu_result_i  in  DATA_W  ALU result
- alu_zero_i  in  1  ALU zero flag
- out_valid_o  out  1  response valid
- out_ready_i  in  1  response accept
- result_o  out  DATA_W  captured result
- zero_o  out  1  captured zero flag
- branch_taken_o  out  1  branch decision (beq/bne only)
- err_o  out  1  illegal op flag

Behaviour:
- Decode, aluop -> code:
  - 1 -> 2; 2 -> 3; 3 -> 7; 4 -> 10; 5 -> 11; 6 -> 1; 7 -> 2.
  - 0 uses funct: 0x24 -> 0 and; 0x25 -> 1 or; 0x20 -> 2 add; 0x2A -> 4 slt; 0x18 -> 5 mul; 0x22 -> 6 sub; 0x03 -> 8 sra; 0x07 -> 9 srav; 0x2C -> 12 sgt.
  - aluop 8..15, or any other funct, is illegal.
- Operand select:
  - sra: src1 = {21'b0, shamt_i, 6'b0}, src2 = rt.
  - srav, R-type default, beq, bne: src1 = rs, src2 = rt.
  - addi, sltiu, ori, lw/sw, lui: src1 = rs, src2 = imm.
- FSM states:
  - IDLE: ready_o = 1.
  - EXEC: ALU inputs driven.
  - RESP: out_valid_o = 1.
- Transitions:
  - IDLE: valid_i & ready_o -> capture code/operands into output regs, load cycle counter, go EXEC. An illegal op skips EXEC: go RESP with err_o = 1, result_o = 0, zero_o = 0.
  - EXEC: counter loaded with MUL_LAT for code 5, else 1. Decrement each cycle; when counter == 1, capture alu_result_i/alu_zero_i, go RESP.
  - RESP: outputs held. out_ready_i -> IDLE, out_valid_o deasserts the next cycle. No accept in RESP (ready_o = 0).
- Latency:
  - Accept at edge N -> out_valid_o high from cycle N+2 for non-mul; N+1+MUL_LAT for mul; N+1 for illegal.
  - Minimum period between accepts is 3 cycles.
- alu_ctrl_o/src1/src2 are registered. They change only on accept and are stable through EXEC and RESP.
- branch_taken_o = captured zero for codes 7 and 10, else 0. Code 7 gives ALU 0 when equal; code 10 gives 0 when not equal, so zero = 1 means taken in both cases.
- err_o is cleared on the next legal accept.
- Reset (any state, including mid-EXEC): state IDLE. All outputs 0 except ready_o, which is 1 from the cycle after reset. In-flight op dropped, counter 0.
- valid_i while not in IDLE: ignored, and the requester must hold it. Operand changes on the inputs while busy have no effect.
- out_ready_i held high continuously: one response per op, never duplicated.

Test Plan:
- Reset: assert rst_i 2 cycles mid-mul EXEC -> ready_o = 1, out_valid_o = 0, alu_ctrl_o = 0, result_o = 0; no response for the dropped op.
- add: aluop 0, funct 0x20, rs = 5, rt = 7 -> alu_ctrl_o = 2 on cycle N+1; out_valid_o at N+2, result_o = 12, zero_o = 0.
- mul: funct 0x18, rs = 6, rt = -3, MUL_LAT = 4 -> alu_ctrl_o = 5 held 4 cycles; result_o = 0xFFFFFFEE at N+5; ready_o low throughout.
- Branches: aluop 3, rs = rt = 9 -> code 7, branch_taken_o = 1. aluop 4, rs = 9, rt = 9 -> code 10, branch_taken_o = 0.
- sra staging: funct 0x03, shamt 4, rt = 0x80000000 -> alu_src1_o = 0x100, result_o = 0xF8000000.
- Illegal and backpressure: aluop 0, funct 0x3F -> err_o = 1, result_o = 0 at N+1. Hold out_ready_i = 0 for 5 cycles -> outputs stable and valid_i ignored. Release -> IDLE next cycle; next legal op clears err_o.
